// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses Instruction_mem and fills IF/ID.
// Optional FETCH_MISALIGN_TRAP_EN: align redirect targets and raise sticky fetch_fault.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] pc_seq;

  // The EX-stage branch is older than the ID-stage jump, so it wins.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_seq   = pc_q + XLEN'(PC_STEP);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign redirect_pc = {target[XLEN-1:2], 2'b00};
  assign fault_d     = fault_q | (redirect & (target[1:0] != 2'b00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fetch_fault = fault_q;
`else
  assign redirect_pc = target;
  assign fetch_fault = 1'b0;
`endif

  // Next PC: redirect > stall hold > sequential; flush never moves the PC.
  always_comb begin
    pc_d = pc_seq;
    if (redirect)   pc_d = redirect_pc;
    else if (stall) pc_d = pc_q;
  end

  // IF/ID: bubble on redirect/flush, hold on stall, otherwise capture the fetch.
  always_comb begin
    instr_d = imem_data;
    pc4_d   = pc_seq;
    valid_d = 1'b1;
    if (redirect || flush) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule
